// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: decoupling FIFO between predecode and rename/dispatch.
// Holds up to DEPTH packed fetch bundles and absorbs rename stalls.
// Optional same-cycle bypass of an empty queue: define FETCH_BUNDLE_QUEUE_BYPASS_EN.
module fetch_bundle_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 256,
    parameter int CNT_W = 16
) (
    input  logic                     cpu_clock_i,
    input  logic                     cpu_reset_i,
    input  logic                     flush_i,
    input  logic                     enq_valid_i,
    input  logic [WIDTH-1:0]         enq_bundle_i,
    output logic                     enq_busy_o,
    output logic                     deq_valid_o,
    output logic [WIDTH-1:0]         deq_bundle_o,
    input  logic                     rn_busy_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic [CNT_W-1:0] stall_cnt;
    logic             empty;
    logic             bypass;
    logic             enq_fire;
    logic             deq_fire;

    // Saturating increment for the performance counter: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign empty       = (count == '0);
    assign enq_busy_o  = (count == FULL_CNT);
    assign occupancy_o = count;
    assign stall_cnt_o = stall_cnt;

`ifdef FETCH_BUNDLE_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming bundle straight to rename; it is
    // only stored when rename cannot take it this cycle.
    assign bypass       = empty && enq_valid_i && !flush_i && !rn_busy_i;
    assign deq_valid_o  = !empty || (enq_valid_i && !flush_i);
    assign deq_bundle_o = empty ? enq_bundle_i : mem[rd_ptr];
`else
    assign bypass       = 1'b0;
    assign deq_valid_o  = !empty;
    assign deq_bundle_o = mem[rd_ptr];
`endif

    // Full blocks enqueue even when the head leaves this cycle (no pass-through).
    assign enq_fire = enq_valid_i && !enq_busy_o && !flush_i && !bypass;
    // Only stored entries advance rd_ptr; a bypassed bundle never touches it.
    assign deq_fire = !empty && !rn_busy_i && !flush_i;

    // Bundle storage: data is not reset, only written on an accepted enqueue.
    always_ff @(posedge cpu_clock_i) begin
        if (enq_fire) begin
            mem[wr_ptr] <= enq_bundle_i;
        end
    end

    // Pointers and occupancy; flush rewinds everything to an empty queue.
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Rename-stall counter: counts cycles with a valid head held by rename.
    // Survives flush; only reset clears it.
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            stall_cnt <= '0;
        end else if (deq_valid_o && rn_busy_i) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
- Decoupling FIFO between the frontend's predecode output and the rename/dispatch stage.
- Captures one fetch bundle per cycle, holding up to two decoded instructions plus their PC and BTB metadata, packed into a WIDTH-bit vector.
- Presents bundles in order to rename and absorbs rename stalls so the fetch pipeline keeps running until the queue fills.
- Its enq_busy_o drives the busy input of the frontend's predecode stage.

Parameters:
DEPTH, 8, number of bundle entries; power of two, minimum 2.
WIDTH, 256, bits per packed bundle (ins0/ins1 decode fields, ins1 valid, bundle PC, BTB type/prediction/target/valid/index/way).
CNT_W, 16, width of the stall performance counter.

Ports:
cpu_clock_i  in  1  sole clock; all state updates on rising edge.
cpu_reset_i  in  1  asynchronous, active-high reset.
flush_i  in  1  pipeline redirect; discards all queued bundles.
enq_valid_i  in  1  frontend presents a bundle this cycle.
enq_bundle_i  in  WIDTH  packed bundle from the frontend.
enq_busy_o  out  1  queue cannot accept; frontend holds its bundle.
deq_valid_o  out  1  head bundle valid toward rename.
deq_bundle_o  out  WIDTH  head bundle.
rn_busy_i  in  1  rename stalled; head is not consumed.
occupancy_o  out  $clog2(DEPTH)+1  current entry count.
stall_cnt_o  out  CNT_W  saturating count of rename-stall cycles.

Behaviour:
- Storage: DEPTH x WIDTH array; rd_ptr/wr_ptr of log2(DEPTH) bits wrap modulo DEPTH; count register 0..DEPTH.
- Enqueue fires when enq_valid_i && !enq_busy_o && !flush_i. Bundle is written at wr_ptr, then wr_ptr increments.
- Dequeue fires when deq_valid_o && !rn_busy_i && !flush_i. rd_ptr increments.
- Count update: count += enq - deq. Simultaneous enq and deq leave count unchanged.
- enq_busy_o = (count == DEPTH), decoded from registered count.
  - No same-cycle pass-through when full: a dequeue while full does not allow an enqueue that cycle.
  - enq_busy_o deasserts the following cycle.
- deq_valid_o = (count != 0). deq_bundle_o = array[rd_ptr].
- Latency: a bundle enqueued in cycle N is visible at deq_valid_o in cycle N+1 (in the non-bypass build).
- Ordering: strict FIFO. Head data stays stable while rn_busy_i is high.
- Flush: in a flush_i cycle, enq and deq are both suppressed. Next edge sets rd_ptr = wr_ptr = 0 and count = 0.
  - deq_valid_o is 0 from the cycle after flush.
  - deq_valid_o may still read 1 during the flush cycle; rename also sees flush_i and ignores it.
  - enq_busy_o is 0 after flush.
- Flush has priority over all other events, including enq_valid_i in the same cycle.
- stall_cnt_o increments by 1 each cycle with deq_valid_o && rn_busy_i.
  - Saturates at all-ones.
  - Not cleared by flush; cleared only by reset.
- Reset (asynchronous, any time, including mid-stall or while full): pointers 0, count 0, stall_cnt_o 0, deq_valid_o 0, enq_busy_o 0, occupancy_o 0.
  - Array contents are not reset; deq_bundle_o is don't-care while deq_valid_o is 0.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap or bubble.
- occupancy_o = count.

Optional Feature:
Macro FETCH_BUNDLE_QUEUE_BYPASS_EN.
- Defined: when count == 0, enq_valid_i && !flush_i && !rn_busy_i, the input bundle drives deq_valid_o/deq_bundle_o combinationally in the same cycle.
  - It is consumed without being written; pointers and count are unchanged.
  - If rn_busy_i is high, the bundle is written normally.
  - When count == 0, deq_valid_o = enq_valid_i && !flush_i.
- Undefined: no bypass; minimum enqueue-to-dequeue latency is 1 cycle as above.

Test Plan:
- Reset, then enq bundles 0xA1..0xA3 on consecutive cycles with rn_busy_i=0 -> deq_bundle_o shows 0xA1,0xA2,0xA3 on cycles 2,3,4 (non-bypass); occupancy_o never exceeds 1.
- rn_busy_i=1, enq 8 bundles -> enq_busy_o=1 after 8th accepted, occupancy_o=8; 9th bundle is held and not lost; release rn_busy_i -> 9 bundles emerge in order.
- Full queue, one dequeue with enq_valid_i=1 the same cycle -> enq not accepted that cycle; occupancy_o=7, then 8 the next cycle.
- 5 entries queued, flush_i=1 with enq_valid_i=1 -> next cycle occupancy_o=0, deq_valid_o=0, enq_busy_o=0; the flush-cycle bundle is dropped.
- Push/pop 20 bundles with a rename-stall pattern busy-1, free-2 -> pointer wrap produces in-order data with no duplicates or skips; stall_cnt_o equals the count of stall cycles with valid head.
- Assert cpu_reset_i asynchronously mid-cycle while full -> all outputs 0 immediately; CNT_W=4 run -> stall_cnt_o saturates at 0xF.
